// File: rtl/sha1_msg_padder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sha1_msg_padder
// Description : Packs a big-endian 32-bit word stream into 512-bit SHA-1 blocks
//               with marker byte, zero fill and 64-bit bit length appended.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module sha1_msg_padder #(
    parameter int BYTE_CNT_W = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    input  logic          in_last,
    input  logic [1:0]    in_bytes,
    output logic          blk_valid,
    input  logic          blk_ready,
    output logic [511:0]  blk_data,
    output logic          blk_first,
    output logic          blk_last,
    output logic          busy
);

    localparam logic [1:0]  c_st_fill  = 2'd0;
    localparam logic [1:0]  c_st_emit  = 2'd1;
    localparam logic [1:0]  c_st_extra = 2'd2;
    localparam logic [31:0] c_marker   = 32'h8000_0000;

    logic [1:0]            r_state;
    logic [3:0]            r_idx;
    logic [BYTE_CNT_W-1:0] r_byte_cnt;
    logic                  r_first;
    logic                  r_extra;
    logic                  r_extra_marker;
    logic                  r_blk_valid;
    logic                  r_blk_last;
    logic                  r_busy;
    logic [31:0]           r_buf [16];

    logic                  w_accept;
    logic                  w_blk_xfer;
    logic                  w_pending;
    logic [2:0]            w_nbytes;
    logic [BYTE_CNT_W-1:0] w_cnt_next;
    logic [63:0]           w_len_new;
    logic [63:0]           w_len_reg;
    logic [4:0]            w_free;
    logic [31:0]           w_word;

    function automatic logic [63:0] f_bit_len(input logic [BYTE_CNT_W-1:0] cnt);
        f_bit_len = {{(61-BYTE_CNT_W){1'b0}}, cnt, 3'b000};
    endfunction

    assign w_accept   = in_valid & in_ready;
    assign w_blk_xfer = r_blk_valid & blk_ready;
    assign w_pending  = in_last & (in_bytes == 2'b00);
    assign w_nbytes   = (in_last && in_bytes != 2'b00) ? {1'b0, in_bytes} : 3'd4;
    assign w_cnt_next = r_byte_cnt + {{(BYTE_CNT_W-3){1'b0}}, w_nbytes};
    assign w_len_new  = f_bit_len(w_cnt_next);
    assign w_len_reg  = f_bit_len(r_byte_cnt);
    // First index not occupied by data or by a marker word still to be written.
    assign w_free     = {1'b0, r_idx} + 5'd1 + {4'd0, w_pending};

    always_comb begin
        w_word = in_data;
        if (in_last) begin
            unique case (in_bytes)
                2'b01:   w_word = {in_data[31:24], 8'h80, 16'h0000};
                2'b10:   w_word = {in_data[31:16], 8'h80, 8'h00};
                2'b11:   w_word = {in_data[31:8], 8'h80};
                default: w_word = in_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= c_st_fill;
            r_idx          <= 4'd0;
            r_byte_cnt     <= '0;
            r_first        <= 1'b1;
            r_extra        <= 1'b0;
            r_extra_marker <= 1'b0;
            r_blk_valid    <= 1'b0;
            r_blk_last     <= 1'b0;
            r_busy         <= 1'b0;
            for (int i = 0; i < 16; i++) r_buf[i] <= '0;
        end else begin
            unique case (r_state)
                c_st_fill: begin
                    if (w_accept) begin
                        r_busy        <= 1'b1;
                        r_buf[r_idx]  <= w_word;
                        r_byte_cnt    <= w_cnt_next;
                        r_idx         <= r_idx + 4'd1;
                        if (in_last) begin
                            if (w_pending && r_idx != 4'd15) r_buf[r_idx + 4'd1] <= c_marker;
                            r_blk_valid <= 1'b1;
                            r_state     <= c_st_emit;
                            if (w_free <= 5'd14) begin
                                r_buf[14]  <= w_len_new[63:32];
                                r_buf[15]  <= w_len_new[31:0];
                                r_blk_last <= 1'b1;
                            end else begin
                                r_extra        <= 1'b1;
                                r_extra_marker <= w_pending && (r_idx == 4'd15);
                            end
                        end else if (r_idx == 4'd15) begin
                            r_blk_valid <= 1'b1;
                            r_state     <= c_st_emit;
                        end
                    end
                end
                c_st_emit: begin
                    if (w_blk_xfer) begin
                        r_blk_valid <= 1'b0;
                        r_blk_last  <= 1'b0;
                        r_idx       <= 4'd0;
                        r_first     <= 1'b0;
                        for (int i = 0; i < 16; i++) r_buf[i] <= '0;
                        if (r_extra) begin
                            r_extra <= 1'b0;
                            r_state <= c_st_extra;
                        end else if (r_blk_last) begin
                            r_first    <= 1'b1;
                            r_byte_cnt <= '0;
                            r_busy     <= 1'b0;
                            r_state    <= c_st_fill;
                        end else begin
                            r_state <= c_st_fill;
                        end
                    end
                end
                c_st_extra: begin
                    if (!r_blk_valid) begin
                        // Buffer was cleared on the previous transfer; only set words are written.
                        if (r_extra_marker) r_buf[0] <= c_marker;
                        r_buf[14]   <= w_len_reg[63:32];
                        r_buf[15]   <= w_len_reg[31:0];
                        r_blk_last  <= 1'b1;
                        r_blk_valid <= 1'b1;
                    end else if (w_blk_xfer) begin
                        r_blk_valid    <= 1'b0;
                        r_blk_last     <= 1'b0;
                        r_extra_marker <= 1'b0;
                        r_first        <= 1'b1;
                        r_byte_cnt     <= '0;
                        r_idx          <= 4'd0;
                        r_busy         <= 1'b0;
                        r_state        <= c_st_fill;
                        for (int i = 0; i < 16; i++) r_buf[i] <= '0;
                    end
                end
                default: r_state <= c_st_fill;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < 16; g++) begin : g_blk_word
            assign blk_data[511-32*g -: 32] = r_buf[g];
        end
    endgenerate

    assign in_ready  = (r_state == c_st_fill);
    assign blk_valid = r_blk_valid;
    assign blk_first = r_first;
    assign blk_last  = r_blk_last;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sha1_msg_padder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_sha1_msg_padder
// Description : Directed self-checking bench for sha1_msg_padder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_sha1_msg_padder;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [1:0]   in_bytes;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    sha1_msg_padder #(.BYTE_CNT_W(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] dw(input int i);
        dw = 32'h1122_3344 ^ (32'(i) * 32'h0101_0101);
    endfunction

    function automatic logic [511:0] put(input logic [511:0] b, input int i, input logic [31:0] v);
        logic [511:0] r;
        r = b;
        r[511-32*i -: 32] = v;
        put = r;
    endfunction

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [31:0] d, input logic last, input logic [1:0] nb);
        int k;
        k = 0;
        in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nb;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) chk("send_timeout", {511'd0, in_ready}, 512'd1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_bytes = 2'b00;
    endtask

    task automatic recv(output logic [511:0] d, output logic f, output logic l);
        int k;
        k = 0;
        while (!blk_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) chk("recv_timeout", {511'd0, blk_valid}, 512'd1);
        d = blk_data; f = blk_first; l = blk_last;
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
    endtask

    initial begin
        logic [511:0] d, e;
        logic         f, l;

        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        in_bytes = 2'b00; blk_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_in_ready",  {511'd0, in_ready},  512'd1);
        chk("rst_blk_valid", {511'd0, blk_valid}, 512'd0);
        chk("rst_blk_data",  blk_data,            512'd0);
        chk("rst_blk_first", {511'd0, blk_first}, 512'd1);
        chk("rst_blk_last",  {511'd0, blk_last},  512'd0);
        chk("rst_busy",      {511'd0, busy},      512'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // "abc": single block
        send(32'h6162_6300, 1'b1, 2'b11);
        chk("abc_latency", {511'd0, blk_valid}, 512'd1);
        chk("abc_busy",    {511'd0, busy},      512'd1);
        recv(d, f, l);
        e = put(put(512'd0, 0, 32'h6162_6380), 15, 32'h0000_0018);
        chk("abc_data",  d, e);
        chk("abc_first", {511'd0, f}, 512'd1);
        chk("abc_last",  {511'd0, l}, 512'd1);
        chk("abc_busy_drop", {511'd0, busy}, 512'd0);
        chk("abc_in_ready",  {511'd0, in_ready}, 512'd1);

        // 55 bytes: marker and length fit in one block
        e = 512'd0;
        for (int i = 0; i < 13; i++) begin
            send(dw(i), 1'b0, 2'b00);
            e = put(e, i, dw(i));
        end
        send(32'hAABB_CCDD, 1'b1, 2'b11);
        e = put(put(e, 13, 32'hAABB_CC80), 15, 32'h0000_01B8);
        recv(d, f, l);
        chk("b55_data",  d, e);
        chk("b55_first", {511'd0, f}, 512'd1);
        chk("b55_last",  {511'd0, l}, 512'd1);

        // 56 bytes: marker in block 1, length spills to block 2
        e = 512'd0;
        for (int i = 0; i < 14; i++) begin
            send(dw(i + 20), (i == 13), 2'b00);
            e = put(e, i, dw(i + 20));
        end
        e = put(e, 14, 32'h8000_0000);
        recv(d, f, l);
        chk("b56_1_data",  d, e);
        chk("b56_1_first", {511'd0, f}, 512'd1);
        chk("b56_1_last",  {511'd0, l}, 512'd0);
        chk("b56_busy_mid", {511'd0, busy}, 512'd1);
        recv(d, f, l);
        chk("b56_2_data",  d, put(512'd0, 15, 32'h0000_01C0));
        chk("b56_2_first", {511'd0, f}, 512'd0);
        chk("b56_2_last",  {511'd0, l}, 512'd1);
        chk("b56_busy_end", {511'd0, busy}, 512'd0);

        // 64 bytes: pure data block then marker-only block
        e = 512'd0;
        for (int i = 0; i < 16; i++) begin
            send(dw(i + 40), (i == 15), 2'b00);
            e = put(e, i, dw(i + 40));
        end
        recv(d, f, l);
        chk("b64_1_data",  d, e);
        chk("b64_1_first", {511'd0, f}, 512'd1);
        chk("b64_1_last",  {511'd0, l}, 512'd0);
        recv(d, f, l);
        chk("b64_2_data",  d, put(put(512'd0, 0, 32'h8000_0000), 15, 32'h0000_0200));
        chk("b64_2_first", {511'd0, f}, 512'd0);
        chk("b64_2_last",  {511'd0, l}, 512'd1);

        // 80 bytes with back-pressure on the first block while in_valid is held
        e = 512'd0;
        for (int i = 0; i < 16; i++) begin
            send(dw(i + 60), 1'b0, 2'b00);
            e = put(e, i, dw(i + 60));
        end
        chk("bp_valid", {511'd0, blk_valid}, 512'd1);
        in_valid = 1'b1; in_data = dw(76); in_last = 1'b0; in_bytes = 2'b00;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_hold_data",     blk_data,           e);
            chk("bp_hold_in_ready", {511'd0, in_ready}, 512'd0);
        end
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
        chk("bp_xfer_valid",    {511'd0, blk_valid}, 512'd0);
        chk("bp_xfer_in_ready", {511'd0, in_ready},  512'd1);
        @(negedge clk);
        for (int i = 17; i < 20; i++) send(dw(i + 60), (i == 19), 2'b00);
        e = 512'd0;
        for (int i = 0; i < 4; i++) e = put(e, i, dw(i + 76));
        e = put(put(e, 4, 32'h8000_0000), 15, 32'h0000_0280);
        recv(d, f, l);
        chk("bp_2_data",  d, e);
        chk("bp_2_first", {511'd0, f}, 512'd0);
        chk("bp_2_last",  {511'd0, l}, 512'd1);

        // Reset mid-message discards the partial block
        for (int i = 0; i < 7; i++) send(dw(i + 90), 1'b0, 2'b00);
        reset_n = 1'b0;
        #1;
        chk("mrst_in_ready",  {511'd0, in_ready},  512'd1);
        chk("mrst_blk_valid", {511'd0, blk_valid}, 512'd0);
        chk("mrst_blk_data",  blk_data,            512'd0);
        chk("mrst_blk_first", {511'd0, blk_first}, 512'd1);
        chk("mrst_blk_last",  {511'd0, blk_last},  512'd0);
        chk("mrst_busy",      {511'd0, busy},      512'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(32'h6162_6300, 1'b1, 2'b11);
        recv(d, f, l);
        chk("mrst_abc_data",  d, put(put(512'd0, 0, 32'h6162_6380), 15, 32'h0000_0018));
        chk("mrst_abc_first", {511'd0, f}, 512'd1);
        chk("mrst_abc_last",  {511'd0, l}, 512'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
